// File: rtl/counter_pkg.sv
// Shared constants and types for the loadable up/down counter.
package counter_pkg;

   localparam int CNT_WIDTH = 4;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   typedef logic [CNT_WIDTH-1:0] count_t;

endpackage

// File: rtl/counter_next.sv
// Combinational next-count: load (clamped to MAX_VAL), wrap-around up, wrap-around down.
module counter_next
   import counter_pkg::*;
#(
   parameter int WIDTH   = CNT_WIDTH,
   parameter int MAX_VAL = 2**WIDTH-1
) (
   input  logic [WIDTH-1:0] count,
   input  logic             updown,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] next_count
);

   localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);

   logic [WIDTH:0] w_cnt_ext;
   logic [WIDTH:0] w_up;
   logic [WIDTH:0] w_dn;
   logic [WIDTH:0] w_sel;

   assign w_cnt_ext = {1'b0, count};

   // Wrap on explicit compare with MAX_VAL so non-power-of-two moduli work.
   assign w_up = (w_cnt_ext == MAX_EXT)       ? '0      : w_cnt_ext + 1'b1;
   assign w_dn = (w_cnt_ext == '0)            ? MAX_EXT : w_cnt_ext - 1'b1;

   // Ternaries (not if/else) so an X on load/updown propagates instead of being masked.
   assign w_sel = load ? {1'b0, d} : ((updown == DIR_UP) ? w_up : w_dn);

   // Only a loaded d can exceed MAX_VAL; saturate it here.
   assign next_count = (w_sel > MAX_EXT) ? MAX_CNT : w_sel[WIDTH-1:0];

endmodule

// File: rtl/updown_load_counter.sv
// Modulo up/down counter with parallel load; async active-high reset register around counter_next.
module updown_load_counter
   import counter_pkg::*;
#(
   parameter int WIDTH   = CNT_WIDTH,
   parameter int MAX_VAL = 2**WIDTH-1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             updown,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] count
);

   generate
      if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH-1) begin : g_bad_max
         $error("updown_load_counter: MAX_VAL out of range 1..2**WIDTH-1");
      end
   endgenerate

   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_next;

   counter_next #(
      .WIDTH   (WIDTH),
      .MAX_VAL (MAX_VAL)
   ) u_next (
      .count      (r_count),
      .updown     (updown),
      .load       (load),
      .d          (d),
      .next_count (w_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_count <= '0;
      else     r_count <= w_next;
   end

   assign count = r_count;

`ifndef SYNTHESIS
   a_in_range: assert property (@(posedge clk) count <= WIDTH'(MAX_VAL));
   a_no_x_ctl: assert property (@(posedge clk) disable iff (rst) !$isunknown({load, updown}));
   a_rst_zero: assert property (@(posedge clk) rst |=> (count == '0));
`endif

endmodule

// File: tb/tb_updown_load_counter.sv
// Directed bench: full-range (MAX 15) and mod-10 (MAX 9) counters on shared stimulus.
module tb_updown_load_counter;
   import counter_pkg::*;

   logic   clk = 1'b0;
   logic   rst;
   logic   updown;
   logic   load;
   count_t d;
   count_t count_a;
   count_t count_b;
   count_t m_b;

   int total  = 0;
   int passed = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   updown_load_counter #(.WIDTH(4)) u_a (
      .clk(clk), .rst(rst), .updown(updown), .load(load), .d(d), .count(count_a)
   );

   updown_load_counter #(.WIDTH(4), .MAX_VAL(9)) u_b (
      .clk(clk), .rst(rst), .updown(updown), .load(load), .d(d), .count(count_b)
   );

   // Independent behavioural reference for the next count.
   function automatic count_t ref_next(count_t cur, logic up, logic ld, count_t dv, int max);
      int c;
      c = int'(cur);
      if (ld)      c = (int'(dv) > max) ? max : int'(dv);
      else if (up) c = (c >= max) ? 0 : c + 1;
      else         c = (c == 0) ? max : c - 1;
      return count_t'(c);
   endfunction

   task automatic chk(string tag, count_t obs, count_t exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One rising edge, then check both instances a little after it.
   task automatic step(string tag, count_t exp_a);
      if (!rst) m_b = ref_next(m_b, updown, load, d, 9);
      @(posedge clk);
      #1;
      chk({tag, "_a"}, count_a, exp_a);
      chk({tag, "_b"}, count_b, m_b);
   endtask

   initial begin
      rst = 1'b1; load = 1'b1; updown = DIR_UP; d = 4'd9; m_b = '0;
      #1;
      chk("rst_async_a", count_a, 4'd0);
      chk("rst_async_b", count_b, 4'd0);
      for (int i = 0; i < 3; i++) step("rst_hold", 4'd0);

      @(negedge clk);
      rst = 1'b0; load = 1'b0; updown = DIR_UP;
      chk("rst_release_a", count_a, 4'd0);
      step("post_rst1", 4'd1);
      step("post_rst2", 4'd2);
      step("post_rst3", 4'd3);

      load = 1'b1; d = 4'd5;
      step("load5", 4'd5);
      load = 1'b0; updown = DIR_UP;
      step("up6", 4'd6);
      step("up7", 4'd7);
      step("up8", 4'd8);

      load = 1'b1; d = 4'd14;
      step("load14", 4'd14);
      chk("clamp14_b", count_b, 4'd9);
      load = 1'b0; updown = DIR_UP;
      step("upwrap15", 4'd15);
      step("upwrap0", 4'd0);
      step("upwrap1", 4'd1);

      load = 1'b1; d = 4'd1;
      step("load1", 4'd1);
      load = 1'b0; updown = DIR_DOWN;
      step("dnwrap0", 4'd0);
      step("dnwrap15", 4'd15);
      chk("dnwrap9_b", count_b, 4'd9);
      step("dnwrap14", 4'd14);

      load = 1'b1; updown = DIR_DOWN; d = 4'd3;
      step("load_prio", 4'd3);

      // Reset between edges with a load pending: clears immediately, load is lost.
      d = 4'd7;
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_a", count_a, 4'd0);
      chk("midrst_b", count_b, 4'd0);
      m_b = '0;
      step("midrst_hold", 4'd0);
      @(negedge clk);
      rst = 1'b0;

      load = 1'b1; d = 4'd12;
      step("load12", 4'd12);
      chk("clamp12_b", count_b, 4'd9);
      load = 1'b0; updown = DIR_UP;
      step("mod_up", 4'd13);
      chk("mod_up_b", count_b, 4'd0);
      updown = DIR_DOWN;
      step("mod_dn", 4'd12);
      chk("mod_dn_b", count_b, 4'd9);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
